// File: rtl/lsu_tlul_host.sv
// lsu_tlul_host: bridges the core LSU req/gnt/rvalid interface onto a TL-UL
// host port facing the data memory.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   data_req_i/_we_i/_be_i/_addr_i/_wdata_i   core request (held until granted)
//   data_gnt_o            request accepted this cycle (combinational)
//   data_rvalid_o         one-cycle response pulse, one cycle after the D beat
//   data_rdata_o          response data, holds until the next response
//   data_err_o            d_error or source mismatch, qualified by rvalid
//   unexp_rsp_o           sticky: stray D beat or source mismatch
//   tl_h_o / tl_h_i       TL-UL A channel + d_ready / D channel + a_ready

package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module lsu_tlul_host
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcW           = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        unexp_rsp_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);

  // Counter and FIFO pointers are sized for the largest legal depth (4);
  // only the first MaxOutstanding FIFO entries are ever addressed.
  localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);
  localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

  logic [2:0]      count_q, count_d;
  logic [SrcW-1:0] src_cnt_q;
  logic [SrcW-1:0] fifo_q [4];
  logic [1:0]      wr_ptr_q, rd_ptr_q;
  logic            rvalid_q, err_q, unexp_q;
  logic [31:0]     rdata_q;

  logic            a_valid, gnt, d_acc, d_stray, src_mismatch;
  logic [SrcW-1:0] head;
  logic [2:0]      opcode;
  logic [1:0]      size, low;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  // Reset also masks a_valid so nothing is granted while state is clearing.
  assign a_valid      = data_req_i & ~reset & (count_q < MaxCnt);
  assign gnt          = a_valid & tl_h_i.a_ready;
  assign d_acc        = tl_h_i.d_valid & (count_q != 3'd0);
  assign d_stray      = tl_h_i.d_valid & (count_q == 3'd0);
  assign head         = fifo_q[rd_ptr_q];
  assign src_mismatch = (tl_h_i.d_source != 8'(head));

  always_comb begin
    count_d = count_q;
    case ({gnt, d_acc})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    opcode = data_we_i ? ((data_be_i == 4'hF) ? 3'd0 : 3'd1) : 3'd4;
    size   = 2'd2;
    low    = 2'd0;
    case (data_be_i)
      4'b0001: begin size = 2'd0; low = 2'd0; end
      4'b0010: begin size = 2'd0; low = 2'd1; end
      4'b0100: begin size = 2'd0; low = 2'd2; end
      4'b1000: begin size = 2'd0; low = 2'd3; end
      4'b0011: begin size = 2'd1; low = 2'd0; end
      4'b1100: begin size = 2'd1; low = 2'd2; end
      default: begin size = 2'd2; low = 2'd0; end
    endcase
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_opcode  = opcode;
    tl_h_o.a_size    = size;
    tl_h_o.a_source  = 8'(src_cnt_q);
    tl_h_o.a_address = (data_addr_i & ~32'h3) | 32'(low);
    tl_h_o.a_mask    = (data_be_i == 4'h0) ? 4'hF : data_be_i;
    tl_h_o.a_data    = data_wdata_i;
    tl_h_o.d_ready   = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      src_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      unexp_q   <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      rvalid_q <= d_acc;
      if (gnt) begin
        fifo_q[wr_ptr_q] <= src_cnt_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        src_cnt_q        <= src_cnt_q + 1'b1;
      end
      if (d_acc) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        rdata_q  <= tl_h_i.d_data;
        err_q    <= tl_h_i.d_error | src_mismatch;
      end
      if ((d_acc & src_mismatch) | d_stray) unexp_q <= 1'b1;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_lsu_tlul_host.sv
module tb_lsu_tlul_host;
  import tlul_pkg::*;

  localparam int MAXO = 2;
  localparam int NSRC = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err, unexp_rsp;
  logic [31:0] data_rdata;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  lsu_tlul_host #(.MaxOutstanding(MAXO), .SrcW(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_req_i   (data_req),
    .data_we_i    (data_we),
    .data_be_i    (data_be),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_gnt_o   (data_gnt),
    .data_rvalid_o(data_rvalid),
    .data_rdata_o (data_rdata),
    .data_err_o   (data_err),
    .unexp_rsp_o  (unexp_rsp),
    .tl_h_o       (h2d),
    .tl_h_i       (d2h)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: sources in flight (queue length is the count),
  // next source, and what the response outputs must show this cycle.
  int          oq[$];
  int          src_m;
  logic        exp_rv, exp_err, exp_unexp;
  logic [31:0] exp_rdata;
  // Device model: sources it has accepted but not yet answered.
  int          dev_q[$];
  logic        last_gnt;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ones(input logic [3:0] be);
    int n = 0;
    for (int i = 0; i < 4; i++) if (be[i]) n++;
    return n;
  endfunction

  function automatic logic [1:0] exp_size(input logic [3:0] be);
    if (ones(be) == 1) return 2'd0;
    if (be == 4'b0011 || be == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [3:0] be);
    int low = 0;
    if (ones(be) == 1) begin
      for (int i = 0; i < 4; i++) if (be[i]) low = i;
    end else if (be == 4'b1100) low = 2;
    return {a[31:2], 2'b00} + low;
  endfunction

  // Called at a negedge with all inputs already applied; checks, advances
  // the model across the next posedge, and returns at the following negedge.
  task automatic step();
    logic exp_av, exp_gnt, nrv;
    int head;
    #1;
    exp_av  = !reset && data_req && (oq.size() < MAXO);
    exp_gnt = exp_av && d2h.a_ready;
    chk_eq("a_valid", 32'(h2d.a_valid), 32'(exp_av));
    chk_eq("gnt", 32'(data_gnt), 32'(exp_gnt));
    if (exp_av) begin
      chk_eq("a_opcode", 32'(h2d.a_opcode), !data_we ? 32'd4 : (data_be == 4'hF ? 32'd0 : 32'd1));
      chk_eq("a_size", 32'(h2d.a_size), 32'(exp_size(data_be)));
      chk_eq("a_address", h2d.a_address, exp_addr(data_addr, data_be));
      chk_eq("a_mask", 32'(h2d.a_mask), data_be == 4'h0 ? 32'hF : 32'(data_be));
      chk_eq("a_data", h2d.a_data, data_wdata);
      chk_eq("a_source", 32'(h2d.a_source), 32'(src_m));
    end
    chk_eq("d_ready", 32'(h2d.d_ready), 32'd1);
    chk_eq("rvalid", 32'(data_rvalid), 32'(exp_rv));
    chk_eq("rdata", data_rdata, exp_rdata);
    if (exp_rv) chk_eq("err", 32'(data_err), 32'(exp_err));
    chk_eq("unexp", 32'(unexp_rsp), 32'(exp_unexp));

    if (reset) begin
      oq.delete();
      src_m = 0; exp_rv = 0; exp_rdata = '0; exp_err = 0; exp_unexp = 0;
    end else begin
      nrv = 0;
      if (d2h.d_valid) begin
        if (oq.size() > 0) begin
          head      = oq.pop_front();
          nrv       = 1;
          exp_rdata = d2h.d_data;
          exp_err   = d2h.d_error || (d2h.d_source != 8'(head));
          if (d2h.d_source != 8'(head)) exp_unexp = 1;
        end else begin
          exp_unexp = 1;
        end
      end
      exp_rv = nrv;
      if (exp_gnt) begin
        oq.push_back(src_m);
        src_m = (src_m + 1) % NSRC;
        dev_q.push_back(int'(h2d.a_source));
      end
    end
    last_gnt = exp_gnt;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic new_req();
    logic [3:0] be_tab [8];
    be_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0};
    data_req   = ($urandom % 4) != 0;
    data_we    = $urandom % 2;
    data_be    = ($urandom % 2) ? be_tab[$urandom % 8] : 4'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  task automatic drive_device(input bit allow);
    int s;
    d2h.d_data  = $urandom;
    d2h.d_error = ($urandom % 8) == 0;
    if (allow && dev_q.size() > 0 && ($urandom % 3) != 0) begin
      s = dev_q.pop_front();
      if (($urandom % 16) == 0) s = s ^ 1;
      d2h.d_valid  = 1;
      d2h.d_source = 8'(s);
    end else begin
      d2h.d_valid  = 0;
      d2h.d_source = 8'($urandom);
    end
  endtask

  initial begin
    reset = 1; data_req = 1; data_we = 0; data_be = 4'hF;
    data_addr = 32'h104; data_wdata = '0;
    d2h = '0;
    src_m = 0; exp_rv = 0; exp_rdata = '0; exp_err = 0; exp_unexp = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    step();                                   // reset values, a_valid masked
    reset = 0;

    // Word load to 0x104, device answers next cycle with 0xDEADBEEF.
    d2h.a_ready = 1;
    step();
    chk_eq("t1_gnt_seen", 32'(last_gnt), 32'd1);
    data_req = 0;
    d2h.d_valid = 1; d2h.d_source = 8'(dev_q.pop_front());
    d2h.d_data = 32'hDEAD_BEEF; d2h.d_error = 0;
    step();
    d2h.d_valid = 0;
    step();
    chk_eq("t1_rdata", data_rdata, 32'hDEAD_BEEF);

    // Byte store to lane 2, then AccessAck with d_error.
    data_req = 1; data_we = 1; data_be = 4'b0100;
    data_addr = 32'h200; data_wdata = 32'h00AB_0000;
    step();
    chk_eq("t2_addr", h2d.a_address, 32'h202);
    data_req = 0;
    d2h.d_valid = 1; d2h.d_source = 8'(dev_q.pop_front()); d2h.d_error = 1;
    step();
    d2h.d_valid = 0;
    step();

    // Randomized traffic with periodic mid-flight resets and stale responses.
    data_req = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!data_req || last_gnt) new_req();
      d2h.a_ready = ($urandom % 4) != 0;
      if ((cyc % 500) == 499) begin
        reset = 1; d2h.d_valid = 0;
        step();
        reset = 0;
        data_req = 0;
        drive_device(1);
        if (!d2h.d_valid) begin
          d2h.d_valid = 1; d2h.d_source = 8'd0;
        end
        step();                               // stray beat: discarded, flagged
        d2h.d_valid = 0;
        step();
        dev_q.delete();
        data_req = 1; data_we = 0; data_be = 4'hF; data_addr = $urandom;
        d2h.a_ready = 1;
        step();
        chk_eq("post_rst_src_gnt", 32'(last_gnt), 32'd1);
      end else begin
        drive_device(1);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
